// File: rtl/mem_wb_skid_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_wb_skid_if : MEM->WB handshake and payload bundle                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mem_wb_skid_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_mem;
  logic [REG_AW-1:0] in_rd;
  logic              in_memtoreg;
  logic              in_regwrite;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_wb_data;
  logic [REG_AW-1:0] out_rd;
  logic              out_regwrite;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_alu, in_mem, in_rd, in_memtoreg, in_regwrite, out_ready,
    input  in_ready, out_valid, out_wb_data, out_rd, out_regwrite, occupancy
  );

  modport slave (
    input  in_valid, in_alu, in_mem, in_rd, in_memtoreg, in_regwrite, out_ready,
    output in_ready, out_valid, out_wb_data, out_rd, out_regwrite, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_wb_skid : MEM->WB stage, two-entry skid buffer, flush, WB mux    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_wb_skid #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter bit ZERO_GUARD = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        flush,
  mem_wb_skid_if.slave     bus
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [REG_AW-1:0] rd;
    logic              memtoreg;
    logic              regwrite;
  } entry_t;

  entry_t     r_main;
  entry_t     r_skid;
  entry_t     w_in;
  logic       r_main_valid;
  logic       r_skid_valid;
  logic [1:0] r_occ;
  logic       w_accept;
  logic       w_pop;
  logic       w_main_free;
  logic       w_main_valid_nxt;
  logic       w_skid_valid_nxt;
  logic       w_rd_ok;

  always_comb begin
    w_in = '{alu: bus.in_alu, mem: bus.in_mem, rd: bus.in_rd,
             memtoreg: bus.in_memtoreg, regwrite: bus.in_regwrite};
    w_accept    = bus.in_valid & ~r_skid_valid;
    w_pop       = r_main_valid & bus.out_ready;
    w_main_free = ~r_main_valid | w_pop;
    w_main_valid_nxt = 1'b0;
    w_skid_valid_nxt = 1'b0;
    if (!flush) begin
      if (w_main_free) begin
        // A held skid entry always has priority: accept is blocked while it is full.
        w_main_valid_nxt = r_skid_valid | w_accept;
        w_skid_valid_nxt = 1'b0;
      end else begin
        w_main_valid_nxt = 1'b1;
        w_skid_valid_nxt = r_skid_valid | w_accept;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_occ        <= 2'd0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_occ        <= {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};
      if (!flush) begin
        if (w_main_free) begin
          if (r_skid_valid) begin
            r_main <= r_skid;
          end else if (w_accept) begin
            r_main <= w_in;
          end
        end else if (!r_skid_valid && w_accept) begin
          r_skid <= w_in;
        end
      end
    end
  end

  generate
    if (ZERO_GUARD) begin : g_zero_guard
      assign w_rd_ok = |r_main.rd;
    end else begin : g_no_guard
      assign w_rd_ok = 1'b1;
    end
  endgenerate

  assign bus.in_ready     = ~r_skid_valid;
  assign bus.out_valid    = r_main_valid;
  assign bus.out_wb_data  = r_main.memtoreg ? r_main.mem : r_main.alu;
  assign bus.out_rd       = r_main.rd;
  assign bus.out_regwrite = r_main_valid & r_main.regwrite & w_rd_ok;
  assign bus.occupancy    = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_wb_skid : directed vector bench for mem_wb_skid               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_wb_skid;

  logic clk;
  logic reset;
  logic flush;
  int   n_pass;
  int   n_total;

  mem_wb_skid_if #(.DATA_W(32), .REG_AW(5)) bus ();

  mem_wb_skid #(.DATA_W(32), .REG_AW(5), .ZERO_GUARD(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rd;
    logic        m2r;
    logic        rw;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic [1:0]  e_occ;
    logic        e_ir;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic v, logic [31:0] alu, logic [31:0] mem, logic [4:0] rd,
                              logic m2r, logic rw, logic ordy, logic fl,
                              logic e_ov, logic [31:0] e_data, logic [4:0] e_rd,
                              logic e_rw, logic [1:0] e_occ, logic e_ir);
    vec_t t;
    t.v = v; t.alu = alu; t.mem = mem; t.rd = rd; t.m2r = m2r; t.rw = rw;
    t.ordy = ordy; t.fl = fl; t.e_ov = e_ov; t.e_data = e_data; t.e_rd = e_rd;
    t.e_rw = e_rw; t.e_occ = e_occ; t.e_ir = e_ir;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act !== want) $display("FAIL %s: got %h, required %h", nm, act, want);
    else n_pass++;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] rd, input logic m2r, input logic rw,
                       input logic ordy, input logic fl);
    bus.in_valid    = v;
    bus.in_alu      = alu;
    bus.in_mem      = mem;
    bus.in_rd       = rd;
    bus.in_memtoreg = m2r;
    bus.in_regwrite = rw;
    bus.out_ready   = ordy;
    flush           = fl;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // reset / single entry
    vq.push_back(mk(1, 32'h11, 0, 3, 0, 1, 1, 0, 1, 32'h11, 3, 1, 1, 1));
    // full-rate stream
    for (int k = 1; k <= 5; k++)
      vq.push_back(mk(1, k, 0, 1, 0, 1, 1, 0, 1, k, 1, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    // stream with a 3-cycle WB stall while 2 is at the head
    vq.push_back(mk(1, 1, 0, 1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1));
    vq.push_back(mk(1, 2, 0, 1, 0, 1, 1, 0, 1, 2, 1, 1, 1, 1));
    vq.push_back(mk(1, 3, 0, 1, 0, 1, 0, 0, 1, 2, 1, 1, 2, 0));
    vq.push_back(mk(1, 4, 0, 1, 0, 1, 0, 0, 1, 2, 1, 1, 2, 0));
    vq.push_back(mk(1, 4, 0, 1, 0, 1, 0, 0, 1, 2, 1, 1, 2, 0));
    vq.push_back(mk(1, 4, 0, 1, 0, 1, 1, 0, 1, 3, 1, 1, 1, 1));
    vq.push_back(mk(1, 4, 0, 1, 0, 1, 1, 0, 1, 4, 1, 1, 1, 1));
    vq.push_back(mk(1, 5, 0, 1, 0, 1, 1, 0, 1, 5, 1, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    // writeback mux and register-0 guard
    vq.push_back(mk(1, 5, 32'hDEADBEEF, 0, 1, 1, 1, 0, 1, 32'hDEADBEEF, 0, 0, 1, 1));
    vq.push_back(mk(1, 5, 32'hDEADBEEF, 7, 1, 1, 1, 0, 1, 32'hDEADBEEF, 7, 1, 1, 1));
    vq.push_back(mk(1, 32'hA5, 32'h1234, 9, 0, 0, 1, 0, 1, 32'hA5, 9, 0, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    // flush with both entries full, then flush while skid could accept
    vq.push_back(mk(1, 32'h21, 0, 2, 0, 1, 0, 0, 1, 32'h21, 2, 1, 1, 1));
    vq.push_back(mk(1, 32'h22, 0, 2, 0, 1, 0, 0, 1, 32'h21, 2, 1, 2, 0));
    vq.push_back(mk(1, 32'h23, 0, 2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(1, 32'h24, 0, 2, 0, 1, 0, 0, 1, 32'h24, 2, 1, 1, 1));
    vq.push_back(mk(1, 32'h25, 0, 2, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(1, 32'h26, 0, 2, 0, 1, 1, 0, 1, 32'h26, 2, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid",    bus.out_valid,    0);
    check("rst_out_regwrite", bus.out_regwrite, 0);
    check("rst_occupancy",    bus.occupancy,    0);
    check("rst_in_ready",     bus.in_ready,     1);
    check("rst_out_wb_data",  bus.out_wb_data,  0);
    check("rst_out_rd",       bus.out_rd,       0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].v, vq[i].alu, vq[i].mem, vq[i].rd, vq[i].m2r, vq[i].rw, vq[i].ordy, vq[i].fl);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i),    bus.out_valid,    vq[i].e_ov);
      check($sformatf("v%0d_out_regwrite", i), bus.out_regwrite, vq[i].e_rw);
      check($sformatf("v%0d_occupancy", i),    bus.occupancy,    vq[i].e_occ);
      check($sformatf("v%0d_in_ready", i),     bus.in_ready,     vq[i].e_ir);
      if (vq[i].e_ov) begin
        check($sformatf("v%0d_out_wb_data", i), bus.out_wb_data, vq[i].e_data);
        check($sformatf("v%0d_out_rd", i),      bus.out_rd,      vq[i].e_rd);
      end
    end

    // asynchronous reset with both entries held
    drive(1, 32'h31, 0, 4, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    drive(1, 32'h32, 0, 4, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    check("pre_arst_occupancy", bus.occupancy, 2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_occupancy", bus.occupancy, 0);
    check("arst_in_ready",  bus.in_ready,  1);
    reset = 1'b0;
    drive(1, 32'h41, 0, 4, 0, 1, 1, 0);
    @(posedge clk);
    #1;
    check("post_arst_out_valid",   bus.out_valid,   1);
    check("post_arst_out_wb_data", bus.out_wb_data, 32'h41);
    check("post_arst_occupancy",   bus.occupancy,   1);

    // reset dominates flush
    drive(1, 32'h51, 0, 5, 0, 1, 0, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_flush_out_valid", bus.out_valid, 0);
    check("rst_flush_wb_data",   bus.out_wb_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
